// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/freeze controller.
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] regAddr_t;

    localparam regAddr_t ZERO_REG = '0;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        ERR
    } pipeState_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and stage-register controls exchanged between the controller and the pipeline.
interface pipe_hazard_ctrl_if;
    import pipe_pkg::*;

    regAddr_t id_rs_addr;
    regAddr_t id_rt_addr;
    logic     id_use_rt;
    logic     ex_mem_read;
    regAddr_t ex_rt_addr;
    logic     mem_access;
    logic     mem_ack;

    logic     pc_write;
    logic     ifid_write;
    logic     idex_bubble;
    logic     idex_hold;
    logic     exmem_hold;
    logic     mem_req;
    logic     timeout_err;

    // The controller is the master: it observes the pipeline and drives its controls.
    modport master (
        input  id_rs_addr, id_rt_addr, id_use_rt, ex_mem_read, ex_rt_addr, mem_access, mem_ack,
        output pc_write, ifid_write, idex_bubble, idex_hold, exmem_hold, mem_req, timeout_err
    );

    modport slave (
        output id_rs_addr, id_rt_addr, id_use_rt, ex_mem_read, ex_rt_addr, mem_access, mem_ack,
        input  pc_write, ifid_write, idex_bubble, idex_hold, exmem_hold, mem_req, timeout_err
    );

endinterface

// File: rtl/luse_detect.sv
// Combinational load-use comparator between the instruction in ID and the load in ID/EX.
module luse_detect
    import pipe_pkg::*;
(
    input  regAddr_t id_rs_addr,
    input  regAddr_t id_rt_addr,
    input  logic     id_use_rt,
    input  logic     ex_mem_read,
    input  regAddr_t ex_rt_addr,
    output logic     luse
);

    logic rsMatch;
    logic rtMatch;

    assign rsMatch = (ex_rt_addr == id_rs_addr);
    assign rtMatch = id_use_rt && (ex_rt_addr == id_rt_addr);
    // A load into $zero never produces a value worth waiting for.
    assign luse    = ex_mem_read && (ex_rt_addr != ZERO_REG) && (rsMatch || rtMatch);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall and data-memory freeze controller for the 5-stage pipeline.
// Optional HAZARD_STATS_EN adds saturating luse_cnt / mem_wait_cnt statistics outputs.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.master hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       luse_cnt,
    output logic [31:0]       mem_wait_cnt
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    pipeState_t       state, nextState;
    logic [CNT_W-1:0] waitCnt, nextCnt;
    logic             luse;
    logic             freeze;
    logic             runOutputs;
    logic             pcWrite, ifidWrite, idexBubble, idexHold, exmemHold, memReq, timeoutErr;

    luse_detect uLuse (
        .id_rs_addr  (hz.id_rs_addr),
        .id_rt_addr  (hz.id_rt_addr),
        .id_use_rt   (hz.id_use_rt),
        .ex_mem_read (hz.ex_mem_read),
        .ex_rt_addr  (hz.ex_rt_addr),
        .luse        (luse)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextCnt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        nextState  = state;
        nextCnt    = waitCnt;
        freeze     = 1'b0;
        runOutputs = 1'b0;
        memReq     = 1'b0;
        timeoutErr = 1'b0;
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexBubble = 1'b0;
        idexHold   = 1'b0;
        exmemHold  = 1'b0;

        case (state)
            RUN: begin
                memReq = hz.mem_access;
                if (hz.mem_access && !hz.mem_ack) begin
                    freeze    = 1'b1;
                    nextState = WAIT;
                    nextCnt   = CNT_W'(1);
                end else begin
                    runOutputs = 1'b1;
                end
            end
            WAIT: begin
                memReq = 1'b1;
                // An acknowledge on the timeout cycle still completes the access.
                if (hz.mem_ack) begin
                    runOutputs = 1'b1;
                    nextState  = RUN;
                    nextCnt    = '0;
                end else if (waitCnt == TIMEOUT_CNT) begin
                    freeze    = 1'b1;
                    nextState = ERR;
                end else begin
                    freeze  = 1'b1;
                    nextCnt = waitCnt + 1'b1;
                end
            end
            ERR: begin
                freeze     = 1'b1;
                timeoutErr = 1'b1;
            end
            default: begin
                nextState = RUN;
                nextCnt   = '0;
            end
        endcase

        // Memory freeze is decided first, so a bubble never lands on a held ID/EX.
        if (freeze) begin
            idexHold  = 1'b1;
            exmemHold = 1'b1;
        end else if (runOutputs) begin
            if (luse) begin
                idexBubble = 1'b1;
            end else begin
                pcWrite   = 1'b1;
                ifidWrite = 1'b1;
            end
        end

        if (rst) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            idexBubble = 1'b1;
            idexHold   = 1'b0;
            exmemHold  = 1'b0;
            memReq     = 1'b0;
            timeoutErr = 1'b0;
        end
    end

    assign hz.pc_write    = pcWrite;
    assign hz.ifid_write  = ifidWrite;
    assign hz.idex_bubble = idexBubble;
    assign hz.idex_hold   = idexHold;
    assign hz.exmem_hold  = exmemHold;
    assign hz.mem_req     = memReq;
    assign hz.timeout_err = timeoutErr;

`ifdef HAZARD_STATS_EN
    logic luseStall;
    logic memWaitCycle;

    assign luseStall    = runOutputs && luse;
    assign memWaitCycle = (state == WAIT) && freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            luse_cnt     <= '0;
            mem_wait_cnt <= '0;
        end else begin
            if (luseStall && (luse_cnt != '1))
                luse_cnt <= luse_cnt + 32'd1;
            if (memWaitCycle && (mem_wait_cnt != '1))
                mem_wait_cnt <= mem_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard/memory scenarios followed by random traffic.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 4;

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] lc;
        logic [31:0] wc;
        string       tag;
    } exp_t;

    logic clk;
    logic rst;
    pipe_hazard_ctrl_if hz();

`ifdef HAZARD_STATS_EN
    logic [31:0] luseCnt;
    logic [31:0] memWaitCnt;
`endif

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.master)
`ifdef HAZARD_STATS_EN
        ,
        .luse_cnt     (luseCnt),
        .mem_wait_cnt (memWaitCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t expQ[$];
    int   nCompared = 0;
    int   nMismatch = 0;

    // Reference model: is the pipeline in error, and how many wait cycles into an access it is.
    bit errored   = 0;
    int waitCycle = 0;
    int luseTotal = 0;
    int waitTotal = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatch++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Output vector order: pc_write, ifid_write, idex_bubble, idex_hold, exmem_hold, mem_req, timeout_err
    task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit useRt,
                        input bit memRead, input logic [4:0] exRt, input bit acc, input bit ack,
                        input string tag);
        exp_t e;
        bit   hazard;
        bit   stallMem;
        bit   req;
        @(posedge clk);
        #1;
        rst            = r;
        hz.id_rs_addr  = rs;
        hz.id_rt_addr  = rt;
        hz.id_use_rt   = useRt;
        hz.ex_mem_read = memRead;
        hz.ex_rt_addr  = exRt;
        hz.mem_access  = acc;
        hz.mem_ack     = ack;

        e.tag = tag;
        e.lc  = luseTotal;
        e.wc  = waitTotal;
        hazard = memRead && exRt != 0 && (exRt == rs || (useRt && exRt == rt));

        if (r) begin
            e.ctl = 7'b0010000;
            errored = 0;
            waitCycle = 0;
            luseTotal = 0;
            waitTotal = 0;
        end else if (errored) begin
            e.ctl = 7'b0001101;
        end else begin
            req      = (waitCycle > 0) ? 1'b1 : acc;
            stallMem = (waitCycle > 0) ? !ack : (acc && !ack);
            if (stallMem) begin
                e.ctl = {5'b00011, req, 1'b0};
                if (waitCycle > 0) waitTotal++;
                if (waitCycle == TIMEOUT) errored = 1;
                else waitCycle++;
            end else begin
                e.ctl = hazard ? {5'b00100, req, 1'b0} : {5'b11000, req, 1'b0};
                if (hazard) luseTotal++;
                waitCycle = 0;
            end
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input string tag);
        step(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, tag);
    endtask

    initial begin : monitor
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e   = expQ.pop_front();
                act = {hz.pc_write, hz.ifid_write, hz.idex_bubble, hz.idex_hold,
                       hz.exmem_hold, hz.mem_req, hz.timeout_err};
                check(e.tag, {25'd0, act}, {25'd0, e.ctl});
`ifdef HAZARD_STATS_EN
                check({e.tag, "_luse_cnt"}, luseCnt, e.lc);
                check({e.tag, "_wait_cnt"}, memWaitCnt, e.wc);
`endif
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        hz.id_rs_addr = '0; hz.id_rt_addr = '0; hz.id_use_rt = 0;
        hz.ex_mem_read = 0; hz.ex_rt_addr = '0; hz.mem_access = 0; hz.mem_ack = 0;

        step(1, 0, 0, 0, 0, 0, 0, 0, "reset0");
        step(1, 0, 0, 0, 0, 0, 1, 0, "reset1");
        idle("idle");

        step(0, 5'd8, 5'd3, 0, 1, 5'd8, 0, 0, "luse_rs");
        idle("after_bubble");
        step(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, "luse_zero_reg");
        step(0, 5'd1, 5'd9, 1, 1, 5'd9, 0, 0, "luse_rt");
        step(0, 5'd1, 5'd9, 0, 1, 5'd9, 0, 0, "rt_unused");

        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, "mem_ack_first");
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, "mem_start");
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, "mem_w1");
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, "mem_w2");
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, "mem_w3_ack");
        idle("mem_done");

        step(0, 5'd7, 5'd0, 0, 1, 5'd7, 1, 0, "luse_and_freeze");
        step(0, 5'd7, 5'd0, 0, 1, 5'd7, 1, 0, "luse_in_wait");
        step(0, 5'd7, 5'd0, 0, 1, 5'd7, 1, 1, "ack_with_luse");
        idle("after_sim");

        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, "edge_start");
        for (int i = 1; i < TIMEOUT; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, "edge_wait");
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, "ack_at_timeout");
        idle("no_error");

        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, "to_start");
        for (int i = 1; i <= TIMEOUT; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, "to_wait");
        step(0, 5'd3, 5'd3, 1, 1, 5'd3, 1, 1, "err_sticky");
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, "err_sticky2");
        step(1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, "reset_in_err");
        idle("after_err_reset");

        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, "mw_start");
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, "mw_w1");
        step(1, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, "reset_mid_wait");
        step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 1, "run_after_reset");

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 3), "random");
        end

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Stall and freeze controller for the 5-stage MIPS pipeline. It detects load-use hazards between the ID stage and the ID/EX register and inserts one bubble. It sequences variable-latency data-memory accesses by freezing every stage register until the memory acknowledges. It sits beside the IF/ID, ID/EX and EX/MEM registers and drives their write/hold/bubble controls and the PC write enable.

## Interface
- MEM_TIMEOUT, 16: maximum cycles without `mem_ack` (counted from the first wait cycle) before the error state is entered.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- id_rs_addr  input  5  Rs field of the instruction in ID.
- id_rt_addr  input  5  Rt field of the instruction in ID.
- id_use_rt  input  1  instruction in ID reads Rt as a source (R-type, store).
- ex_mem_read  input  1  MemRead output of the ID/EX register.
- ex_rt_addr  input  5  RtAddr output of the ID/EX register.
- mem_access  input  1  EX/MEM register holds a load or store.
- mem_ack  input  1  data memory has completed the current access this cycle.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID register load enable.
- idex_bubble  output  1  force all ID/EX control fields (ALUOp, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg) to 0 on this load.
- idex_hold  output  1  ID/EX register keeps its contents.
- exmem_hold  output  1  EX/MEM register keeps its contents.
- mem_req  output  1  request to data memory.
- timeout_err  output  1  sticky memory-timeout flag.

## Operation
- Load-use hazard (`luse`) is asserted when all of the following hold:
  - `ex_mem_read` = 1 and `ex_rt_addr` != 0;
  - and either `ex_rt_addr` == `id_rs_addr`, or `id_use_rt` = 1 and `ex_rt_addr` == `id_rt_addr`.
- `freeze` means `pc_write`=0, `ifid_write`=0, `idex_hold`=1, `exmem_hold`=1 and `idex_bubble`=0.
- State RUN:
  - `mem_req` = `mem_access`.
  - If `mem_access` and not `mem_ack`: freeze this cycle, go to WAIT, counter set to 1.
  - Otherwise, if `luse`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1, holds 0, and stay in RUN.
  - Otherwise: `pc_write`=1, `ifid_write`=1, all others 0.
- State WAIT:
  - `mem_req`=1.
  - If `mem_ack`: no freeze this cycle; outputs are the RUN non-memory outputs (`luse` rule applies); next state RUN, counter cleared.
  - Else if counter == MEM_TIMEOUT: freeze, next state ERR.
  - Else: freeze, counter increments.
- State ERR: freeze, `mem_req`=0, `timeout_err`=1. Only `rst` leaves ERR.
- Priority: memory freeze overrides load-use. A bubble is never inserted while ID/EX is held.
- Counter saturates at MEM_TIMEOUT and never wraps.

## Timing
- Hazard decode and output generation are combinational from the current inputs and state. The state and counter are registered.
- A load-use stall lasts exactly 1 cycle. On the next edge the bubble enters ID/EX, which clears `luse`.
- A memory access acknowledged in its first cycle costs 0 stall cycles. If `mem_ack` arrives in wait cycle k, the stall is k cycles.
- `timeout_err` rises on the cycle after the counter reaches MEM_TIMEOUT without `mem_ack`, i.e. MEM_TIMEOUT+1 cycles after the access begins.
- While `rst`=1:
  - Outputs are `pc_write`=0, `ifid_write`=0, `idex_bubble`=1, `idex_hold`=0, `exmem_hold`=0, `mem_req`=0, `timeout_err`=0.
  - Next state is RUN and the counter is cleared.
  - This applies in any state, including mid-WAIT and ERR.
- If `mem_ack` and the timeout condition occur in the same cycle, `mem_ack` wins.

## Configuration
- `HAZARD_STATS_EN` defined:
  - Adds output `luse_cnt` (32 bits), which increments on each load-use stall cycle.
  - Adds output `mem_wait_cnt` (32 bits), which increments on each cycle with `freeze` in WAIT.
  - Both counters clear on `rst`, saturate at all-ones, and do not count in ERR.
- Not defined: neither output exists and no counter logic is generated. All other behaviour is identical.

## Structure
- Shared package `pipe_pkg`: state enum (RUN, WAIT, ERR), the register-address width constant (5) and the zero register constant (0).
- Sub-module `luse_detect`: purely combinational hazard comparator producing `luse`. All sequential logic stays in `pipe_hazard_ctrl`.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1. Repeat with ex_rt=0 -> no stall.
- Rt dependency: ex_rt=9, id_rt=9 -> stall with id_use_rt=1; no stall with id_use_rt=0.
- Memory wait: mem_access=1, mem_ack arrives 3 cycles later -> freeze for exactly 3 cycles, mem_req=1 throughout, state back to RUN.
- Timeout: MEM_TIMEOUT=4, mem_ack never asserted -> timeout_err=1 from cycle 5 after access start, and remains asserted until rst.
- Simultaneous events: luse and memory freeze together -> idex_bubble=0 and idex_hold=1; mem_ack in the same cycle as the timeout edge -> no error.
- Reset mid-WAIT: assert rst during WAIT -> reset output values on that cycle, and RUN with counter 0 on the next cycle. With HAZARD_STATS_EN, the counters read 0 after reset.
